// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter
//   Shares one memory port between an instruction cache (I), a data cache (D)
//   and a DMA engine. DMA has absolute priority whenever the arbiter is idle.
//   Once DMA is granted it keeps the bus for as long as it holds DMA_BR. Two
//   caches competing from idle are served round-robin. A granted cache is
//   never preempted. Every grant is taken from IDLE, so each grant costs one
//   bubble cycle. A cache that holds its lock keeps the grant for burst
//   (line-fill) transfers.
//
// Ports
//   clk, reset                    clock, asynchronous active-high reset
//   I_readM, I_lock, I_address    instruction-cache request
//   D_readM, D_writeM, D_lock,
//   D_address, D_wdata            data-cache request
//   DMA_BR / DMA_BG               DMA bus request / registered bus grant
//   DMA_readM, DMA_writeM,
//   DMA_address, DMA_wdata        DMA access, used only while DMA_BG=1
//   I_ready, D_ready, DMA_ready   completion strobe for the granted requester
//   RDATA                         memory read data broadcast to everyone
//   MEMORY_*                      memory-side port
// ---------------------------------------------------------------------------
module memory_arbiter #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 I_readM,
  input  logic                 I_lock,
  input  logic [WORD_SIZE-1:0] I_address,
  input  logic                 D_readM,
  input  logic                 D_writeM,
  input  logic                 D_lock,
  input  logic [WORD_SIZE-1:0] D_address,
  input  logic [WORD_SIZE-1:0] D_wdata,
  input  logic                 DMA_BR,
  output logic                 DMA_BG,
  input  logic                 DMA_readM,
  input  logic                 DMA_writeM,
  input  logic [WORD_SIZE-1:0] DMA_address,
  input  logic [WORD_SIZE-1:0] DMA_wdata,
  output logic                 I_ready,
  output logic                 D_ready,
  output logic                 DMA_ready,
  output logic [WORD_SIZE-1:0] RDATA,
  output logic                 MEMORY_readM,
  output logic                 MEMORY_writeM,
  output logic [WORD_SIZE-1:0] MEMORY_address,
  output logic [WORD_SIZE-1:0] MEMORY_wdata,
  input  logic [WORD_SIZE-1:0] MEMORY_rdata,
  input  logic                 MEMORY_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_I   = 2'd1,
    GNT_D   = 2'd2,
    GNT_DMA = 2'd3
  } state_t;

  // rr_ptr names the cache that wins the next I/D tie.
  localparam logic RR_I = 1'b0;
  localparam logic RR_D = 1'b1;

  state_t state;
  logic   rr_ptr;

  logic i_req;
  logic d_req;
  logic dma_act;

  assign i_req   = I_readM;
  assign d_req   = D_readM | D_writeM;
  assign dma_act = DMA_readM | DMA_writeM;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= RR_D;
      DMA_BG <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (DMA_BR) begin
            state  <= GNT_DMA;
            DMA_BG <= 1'b1;
          end else if (i_req && d_req) begin
            state <= (rr_ptr == RR_D) ? GNT_D : GNT_I;
          end else if (i_req) begin
            state <= GNT_I;
          end else if (d_req) begin
            state <= GNT_D;
          end
        end
        // Without a lock the grant ends on completion, or immediately if the
        // cache has withdrawn its request (abort). A held lock overrides both.
        GNT_I: begin
          if (!I_lock && (MEMORY_ready || !i_req)) begin
            state  <= IDLE;
            rr_ptr <= RR_D;
          end
        end
        GNT_D: begin
          if (!D_lock && (MEMORY_ready || !d_req)) begin
            state  <= IDLE;
            rr_ptr <= RR_I;
          end
        end
        GNT_DMA: begin
          if (!DMA_BR) begin
            state  <= IDLE;
            DMA_BG <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          DMA_BG <= 1'b0;
        end
      endcase
    end
  end

  // Memory port follows the current owner combinationally; idle drives zeros.
  always_comb begin
    MEMORY_readM   = 1'b0;
    MEMORY_writeM  = 1'b0;
    MEMORY_address = '0;
    MEMORY_wdata   = '0;
    case (state)
      GNT_I: begin
        MEMORY_readM   = I_readM;
        MEMORY_address = I_address;
      end
      GNT_D: begin
        MEMORY_readM   = D_readM;
        MEMORY_writeM  = D_writeM;
        MEMORY_address = D_address;
        MEMORY_wdata   = D_wdata;
      end
      GNT_DMA: begin
        MEMORY_readM   = DMA_readM;
        MEMORY_writeM  = DMA_writeM;
        MEMORY_address = DMA_address;
        MEMORY_wdata   = DMA_wdata;
      end
      default: begin
        MEMORY_readM   = 1'b0;
        MEMORY_writeM  = 1'b0;
        MEMORY_address = '0;
        MEMORY_wdata   = '0;
      end
    endcase
  end

  assign I_ready   = (state == GNT_I)   && MEMORY_ready && i_req;
  assign D_ready   = (state == GNT_D)   && MEMORY_ready && d_req;
  assign DMA_ready = (state == GNT_DMA) && MEMORY_ready && dma_act;

  assign RDATA = MEMORY_rdata;

endmodule

// File: tb/tb_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_memory_arbiter
//   Self-checking bench for memory_arbiter: directed scenarios followed by a
//   randomized phase, all compared each cycle against a behavioural owner
//   model ("who holds the bus, who wins the next tie").
// ---------------------------------------------------------------------------
module tb_memory_arbiter;

  localparam int W = 16;

  localparam int OWN_NONE = 0;
  localparam int OWN_I    = 1;
  localparam int OWN_D    = 2;
  localparam int OWN_DMA  = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         I_readM, I_lock;
  logic [W-1:0] I_address;
  logic         D_readM, D_writeM, D_lock;
  logic [W-1:0] D_address, D_wdata;
  logic         DMA_BR, DMA_BG;
  logic         DMA_readM, DMA_writeM;
  logic [W-1:0] DMA_address, DMA_wdata;
  logic         I_ready, D_ready, DMA_ready;
  logic [W-1:0] RDATA;
  logic         MEMORY_readM, MEMORY_writeM;
  logic [W-1:0] MEMORY_address, MEMORY_wdata, MEMORY_rdata;
  logic         MEMORY_ready;

  memory_arbiter #(.WORD_SIZE(W)) dut (
    .clk(clk), .reset(reset),
    .I_readM(I_readM), .I_lock(I_lock), .I_address(I_address),
    .D_readM(D_readM), .D_writeM(D_writeM), .D_lock(D_lock),
    .D_address(D_address), .D_wdata(D_wdata),
    .DMA_BR(DMA_BR), .DMA_BG(DMA_BG),
    .DMA_readM(DMA_readM), .DMA_writeM(DMA_writeM),
    .DMA_address(DMA_address), .DMA_wdata(DMA_wdata),
    .I_ready(I_ready), .D_ready(D_ready), .DMA_ready(DMA_ready),
    .RDATA(RDATA),
    .MEMORY_readM(MEMORY_readM), .MEMORY_writeM(MEMORY_writeM),
    .MEMORY_address(MEMORY_address), .MEMORY_wdata(MEMORY_wdata),
    .MEMORY_rdata(MEMORY_rdata), .MEMORY_ready(MEMORY_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: current bus owner and which cache wins the next tie.
  int owner;
  bit pref_d;

  // DUT outputs sampled at the most recent falling edge.
  logic obs_i, obs_d, obs_bg, obs_rd, obs_wr;
  logic [W-1:0] obs_addr, obs_wdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner  = OWN_NONE;
    pref_d = 1'b1;
  endtask

  task automatic check_cycle();
    logic e_rd, e_wr, e_bg, e_ir, e_dr, e_mr;
    logic [W-1:0] e_a, e_w;
    e_rd = 1'b0; e_wr = 1'b0; e_a = '0; e_w = '0;
    e_ir = 1'b0; e_dr = 1'b0; e_mr = 1'b0;
    e_bg = (owner == OWN_DMA);
    if (owner == OWN_I) begin
      e_rd = I_readM; e_a = I_address;
      e_ir = MEMORY_ready && I_readM;
    end else if (owner == OWN_D) begin
      e_rd = D_readM; e_wr = D_writeM; e_a = D_address; e_w = D_wdata;
      e_dr = MEMORY_ready && (D_readM || D_writeM);
    end else if (owner == OWN_DMA) begin
      e_rd = DMA_readM; e_wr = DMA_writeM; e_a = DMA_address; e_w = DMA_wdata;
      e_mr = MEMORY_ready && (DMA_readM || DMA_writeM);
    end
    check("mem_port", 64'({MEMORY_readM, MEMORY_writeM, MEMORY_address, MEMORY_wdata}),
          64'({e_rd, e_wr, e_a, e_w}));
    check("ready_bg", 64'({DMA_BG, I_ready, D_ready, DMA_ready}),
          64'({e_bg, e_ir, e_dr, e_mr}));
    check("rdata", 64'(RDATA), 64'(MEMORY_rdata));
  endtask

  // Advance the owner model across one rising edge using the sampled inputs.
  task automatic model_update();
    bit wants, locked;
    if (reset) begin
      model_reset();
      return;
    end
    case (owner)
      OWN_NONE: begin
        if (DMA_BR)                                     owner = OWN_DMA;
        else if (I_readM && (D_readM || D_writeM))      owner = pref_d ? OWN_D : OWN_I;
        else if (I_readM)                               owner = OWN_I;
        else if (D_readM || D_writeM)                   owner = OWN_D;
      end
      OWN_I, OWN_D: begin
        wants  = (owner == OWN_I) ? I_readM : (D_readM || D_writeM);
        locked = (owner == OWN_I) ? I_lock  : D_lock;
        // Released after a completed word or a withdrawn request, unless locked;
        // the other cache then wins the next tie.
        if (!locked && (MEMORY_ready || !wants)) begin
          pref_d = (owner == OWN_I);
          owner  = OWN_NONE;
        end
      end
      default: if (!DMA_BR) owner = OWN_NONE;
    endcase
  endtask

  // One clock: check outputs at the falling edge, then model the rising edge.
  task automatic step();
    @(negedge clk);
    MEMORY_rdata = W'($urandom);
    #0;
    obs_i = I_ready; obs_d = D_ready; obs_bg = DMA_BG;
    obs_rd = MEMORY_readM; obs_wr = MEMORY_writeM;
    obs_addr = MEMORY_address; obs_wdata = MEMORY_wdata;
    check_cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    I_readM = 0; I_lock = 0; I_address = '0;
    D_readM = 0; D_writeM = 0; D_lock = 0; D_address = '0; D_wdata = '0;
    DMA_BR = 0; DMA_readM = 0; DMA_writeM = 0; DMA_address = '0; DMA_wdata = '0;
    MEMORY_ready = 0;
  endtask

  initial begin
    int k, first, last, i_during, d_seen, i_seen;
    int log_q[$];
    int exp_order[4];

    reset = 1'b1;
    clear_inputs();
    MEMORY_rdata = '0;
    model_reset();
    #12;
    check("reset_bg", 64'(DMA_BG), 64'(0));
    check("reset_strobes", 64'({MEMORY_readM, MEMORY_writeM, MEMORY_address}), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // Single instruction read at 0x0040, memory ready on the third cycle.
    I_readM = 1; I_address = 16'h0040;
    step();
    check("rd_idle_bubble", 64'(obs_rd), 64'(0));
    step();
    check("rd_granted", 64'({obs_rd, obs_addr, obs_i}), 64'({1'b1, 16'h0040, 1'b0}));
    MEMORY_ready = 1;
    step();
    check("rd_ready", 64'(obs_i), 64'(1));
    clear_inputs();
    step();
    check("rd_back_idle", 64'(obs_rd), 64'(0));

    // Persistent contention: strobes must alternate D, I, D, I.
    I_readM = 1; I_address = 16'h0010;
    D_readM = 1; D_address = 16'h0020;
    MEMORY_ready = 1;
    for (int c = 0; c < 16 && log_q.size() < 4; c++) begin
      step();
      if (obs_d) log_q.push_back(OWN_D);
      if (obs_i) log_q.push_back(OWN_I);
    end
    exp_order = '{OWN_D, OWN_I, OWN_D, OWN_I};
    check("contend_count", 64'(log_q.size()), 64'(4));
    for (int j = 0; j < 4 && j < log_q.size(); j++)
      check("contend_order", 64'(log_q[j]), 64'(exp_order[j]));
    clear_inputs();
    step(); step();

    // Locked 4-word burst on D at 0x0100..0x0103; I must wait it out.
    D_readM = 1; MEMORY_ready = 1;
    k = 0; first = -1; last = -1; i_during = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      D_address = 16'h0100 + 16'(k);
      D_lock = (k < 3);
      if (c >= 1) I_readM = 1;
      step();
      if (obs_d) begin
        check("burst_addr", 64'(obs_addr), 64'(16'h0100 + 16'(k)));
        if (first < 0) first = c;
        last = c;
        k++;
      end
      if (obs_i) i_during++;
    end
    check("burst_words", 64'(k), 64'(4));
    check("burst_no_bubble", 64'(last - first), 64'(3));
    check("burst_i_stalled", 64'(i_during), 64'(0));
    D_readM = 0; D_lock = 0; I_address = 16'h0044;
    i_seen = 0;
    for (int c = 0; c < 4 && i_seen == 0; c++) begin
      step();
      if (obs_i) i_seen = 1;
    end
    check("burst_i_after", 64'(i_seen), 64'(1));
    clear_inputs();
    step(); step();

    // DMA request during a busy D grant; DMA writes 0x1234 to 0x0200.
    D_readM = 1; D_address = 16'h0300;
    step();
    DMA_BR = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("dma_wait_bg", 64'(obs_bg), 64'(0));
    end
    MEMORY_ready = 1;
    step();
    check("dma_d_done", 64'({obs_d, obs_bg}), 64'({1'b1, 1'b0}));
    D_readM = 0; MEMORY_ready = 0;
    DMA_writeM = 1; DMA_address = 16'h0200; DMA_wdata = 16'h1234;
    step();
    check("dma_idle_bubble", 64'(obs_bg), 64'(0));
    step();
    check("dma_write", 64'({obs_bg, obs_wr, obs_addr, obs_wdata}),
          64'({1'b1, 1'b1, 16'h0200, 16'h1234}));
    DMA_BR = 0; DMA_writeM = 0;
    step();
    check("dma_bg_hold", 64'(obs_bg), 64'(1));
    step();
    check("dma_bg_drop", 64'(obs_bg), 64'(0));
    clear_inputs();
    step();

    // Asynchronous reset in the middle of a locked D burst.
    D_readM = 1; D_lock = 1; MEMORY_ready = 1; D_address = 16'h0400;
    step(); step();
    check("arst_pre_grant", 64'(obs_rd), 64'(1));
    #2; reset = 1'b1; model_reset(); #1;
    check("arst_readM", 64'({MEMORY_readM, D_ready}), 64'(0));
    check("arst_bg", 64'(DMA_BG), 64'(0));
    step();
    clear_inputs();
    reset = 1'b0;
    // Asynchronous reset while DMA owns the bus.
    DMA_BR = 1;
    step(); step();
    check("arst_dma_pre", 64'(obs_bg), 64'(1));
    #2; reset = 1'b1; model_reset(); #1;
    check("arst_dma_bg", 64'(DMA_BG), 64'(0));
    step();
    clear_inputs();
    reset = 1'b0;
    step();

    // Abort: D withdraws after one granted cycle without MEMORY_ready.
    D_readM = 1; D_address = 16'h0500;
    d_seen = 0;
    step(); step();
    if (obs_d) d_seen++;
    D_readM = 0;
    step();
    if (obs_d) d_seen++;
    step();
    if (obs_d) d_seen++;
    check("abort_no_ready", 64'(d_seen), 64'(0));
    check("abort_idle", 64'(obs_rd), 64'(0));

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      I_readM      = ($urandom_range(0, 1) == 1);
      I_lock       = ($urandom_range(0, 3) == 0);
      I_address    = W'($urandom);
      D_readM      = ($urandom_range(0, 1) == 1);
      D_writeM     = ($urandom_range(0, 3) == 0);
      D_lock       = ($urandom_range(0, 3) == 0);
      D_address    = W'($urandom);
      D_wdata      = W'($urandom);
      if ($urandom_range(0, 7) == 0) DMA_BR = ~DMA_BR;
      DMA_readM    = ($urandom_range(0, 1) == 1);
      DMA_writeM   = ($urandom_range(0, 1) == 1);
      DMA_address  = W'($urandom);
      DMA_wdata    = W'($urandom);
      MEMORY_ready = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        model_reset();
      end
      step();
      reset = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
